axi4lite_master_interface: RTL and testbench
============================================

# axi4lite_master_interface

AXI4-Lite master that turns a simple single-beat command/response interface into AXI4-Lite read and write transactions. It sits between local control logic (a sequencer or test controller) and any AXI4-Lite slave register block in the design, including our own AXI4-Lite slave interface. Only one transaction is outstanding at a time. A watchdog counter flags slaves that never respond.

## Interface
- C_M_AXI_DATA_WIDTH, 32: data bus width; must be 32 or 64.
- C_M_AXI_ADDR_WIDTH, 11: byte address width.
- C_TIMEOUT_CYCLES, 1024: number of cycles waiting on the AXI bus before timeout_err sets; must be ≥2.
- M_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- M_AXI_ARESETN  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte-lane strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as captured from the slave.
- timeout_err  out  1  sticky watchdog flag.
- timeout_clr  in  1  clears timeout_err.
- busy  out  1  high whenever the FSM is not in IDLE.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths. PROT is always 3'b000.

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
  - WRITE: AW and W phases in parallel; BREADY=1.
  - READ: AR phase, then R phase; RREADY=1 once AR completes.
  - RESP: rsp_valid=1.
- IDLE transitions: on cmd_valid&&cmd_ready, register addr, data and strobe. Go to WRITE if cmd_write=1, otherwise READ.
- Address alignment: the low ADDR_LSB bits of the address are forced to 0 on AWADDR/ARADDR. ADDR_LSB = clog2(DATA_WIDTH)-3.
- WRITE:
  - AWVALID and WVALID both rise on entry.
  - Each one drops independently on the cycle after its own handshake (VALID&&READY sampled high).
  - A BVALID that arrives before both handshakes complete is a protocol error and is ignored; BREADY still acknowledges it.
  - On the B handshake, with both AW and W done: capture BRESP, go to RESP.
- READ:
  - ARVALID rises on entry and drops after the AR handshake.
  - RREADY is high from the cycle after the AR handshake.
  - On the R handshake: capture RDATA and RRESP, go to RESP.
- RESP: hold rsp_* stable until rsp_valid&&rsp_ready, then go to IDLE.
- VALID rule: no AXI VALID is ever deasserted before its handshake completes.
- Watchdog:
  - The counter clears on entry to WRITE/READ and increments every cycle spent in WRITE/READ.
  - When it reaches C_TIMEOUT_CYCLES, timeout_err sets.
  - The transaction keeps waiting; there is no abort.
  - timeout_clr clears the flag. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously) and the FSM returns to IDLE. Any in-flight slave transaction is abandoned.
- Reset values:
  - All AXI VALID/READY outputs, rsp_valid and timeout_err: 0.
  - AWADDR/ARADDR/WDATA/WSTRB and rsp_rdata/rsp_resp/rsp_write: 0.
  - busy: 0.
  - cmd_ready: 1 once reset is deasserted (combinational from the IDLE state).

## Timing
- All AXI outputs are registered; no combinational path from any AXI input to any AXI output.
- Command accepted at edge N: AWVALID/WVALID (or ARVALID) are high from cycle N+1.
- Against a zero-wait slave that accepts AW/W in the same cycle as VALID:
  - BREADY is high from N+1; write response captured at the B handshake.
  - rsp_valid is high the cycle after the B/R handshake.
- cmd_ready is low for the whole transaction, including RESP. A back-to-back command is accepted at earliest the cycle after the rsp handshake.
- Minimum command-to-command period is 4 cycles with a zero-wait slave and rsp_ready tied high.

## Test plan
- Write, paired with our AXI4-Lite slave interface: cmd addr=0x010, data=0xDEADBEEF, strb=0xF. Required: AWADDR=0x010; slave write address = 4; rsp_write=1, rsp_resp=0; one rsp_valid pulse with rsp_ready tied high.
- Read back addr=0x010 (low bits 0x013 also → AWADDR/ARADDR 0x010). Required: rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0.
- Independent AW/W handshakes: bench slave asserts WREADY 3 cycles before AWREADY. Required: WVALID drops after its handshake, AWVALID held until its own, exactly one B accepted; BRESP=2'b10 → rsp_resp=2'b10.
- Back-pressure: RVALID delayed 5 cycles, then rsp_ready held low 4 cycles. Required: RREADY high throughout the wait, rsp_* stable, cmd_ready low until the rsp handshake.
- Watchdog with C_TIMEOUT_CYCLES=8: slave never asserts ARREADY. Required: timeout_err=1 after 8 cycles in READ, ARVALID still 1. Then pulse timeout_clr → flag clears; a late ARREADY/RVALID completes the read normally.
- Reset mid-write: deassert M_AXI_ARESETN while AWVALID=1. Required: AWVALID/WVALID/BREADY go to 0 without waiting for a clock edge, busy=0; after release cmd_ready=1 and a new read completes correctly.

Source files
------------

// File: rtl/axi4lite_master_interface.sv
// axi4lite_master_interface: single-outstanding AXI4-Lite master behind a cmd/rsp handshake
// Ports: M_AXI_ACLK/M_AXI_ARESETN clock and async active-low reset;
//   cmd_* command request (write flag, byte address, data, strobes);
//   rsp_* response (write flag, read data, BRESP/RRESP);
//   timeout_err/timeout_clr sticky watchdog flag and its clear; busy = not idle;
//   M_AXI_* AXI4-Lite master channels AW, W, B, AR, R.
module axi4lite_master_interface #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 11,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              timeout_err,
  input  logic                              timeout_clr,
  output logic                              busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(C_M_AXI_DATA_WIDTH) - 3;
  localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] AMASK = {{(AW-LSB){1'b1}}, {LSB{1'b0}}};
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state, state_nx;
  logic aw_done, w_done, accept, b_hs, r_hs, waiting;
  logic [CW-1:0] cnt;
  assign accept = cmd_valid && cmd_ready;
  // a B arriving before both AW and W completed is ignored, though BREADY still takes it
  assign b_hs = M_AXI_BVALID && M_AXI_BREADY && aw_done && w_done;
  assign r_hs = M_AXI_RVALID && M_AXI_RREADY;
  assign waiting = (state == WRITE) || (state == READ);
  assign cmd_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (cmd_write ? WRITE : READ) : IDLE;
      WRITE:   state_nx = b_hs ? RESP : WRITE;
      READ:    state_nx = r_hs ? RESP : READ;
      default: state_nx = (rsp_valid && rsp_ready) ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      M_AXI_AWADDR <= '0;
      M_AXI_ARADDR <= '0;
      M_AXI_WDATA <= '0;
      M_AXI_WSTRB <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        M_AXI_AWADDR <= cmd_addr & AMASK;
        M_AXI_ARADDR <= cmd_addr & AMASK;
        M_AXI_WDATA <= cmd_wdata;
        M_AXI_WSTRB <= cmd_wstrb;
        M_AXI_AWVALID <= cmd_write;
        M_AXI_WVALID <= cmd_write;
        M_AXI_BREADY <= cmd_write;
        M_AXI_ARVALID <= !cmd_write;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        cnt <= '0;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        M_AXI_AWVALID <= 1'b0;
        aw_done <= 1'b1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        M_AXI_WVALID <= 1'b0;
        w_done <= 1'b1;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY <= 1'b1;
      end
      if (b_hs) begin
        M_AXI_BREADY <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp <= M_AXI_BRESP;
      end
      if (r_hs) begin
        M_AXI_RREADY <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_write <= 1'b0;
        rsp_rdata <= M_AXI_RDATA;
        rsp_resp <= M_AXI_RRESP;
      end
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      // counter saturates so the flag is raised exactly once per transaction
      if (waiting && cnt != CW'(C_TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
      if (waiting && cnt == CW'(C_TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      else if (timeout_clr) timeout_err <= 1'b0;
    end
endmodule

// File: tb/tb_axi4lite_master_interface.sv
// tb_axi4lite_master_interface: directed self-checking bench with a simple AXI4-Lite slave model
module tb_axi4lite_master_interface;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [10:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 1, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic timeout_err, timeout_clr = 0, busy;
  logic [10:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_k = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt, waddr_word;
  logic aw_got, w_got, ar_got, do_b;
  logic [10:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [31:0] mem [0:511];
  int n_cmp = 0, n_fail = 0;

  axi4lite_master_interface #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(11), .C_TIMEOUT_CYCLES(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .timeout_err(timeout_err), .timeout_clr(timeout_clr), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  // slave model: each READY rises once its VALID has waited the programmed number of cycles
  assign awready = awvalid && aw_cnt >= aw_dly;
  assign wready = wvalid && w_cnt >= w_dly;
  assign arready = arvalid && ar_cnt >= ar_dly;
  assign rvalid = ar_got && r_cnt >= r_dly;
  assign rdata = mem[s_araddr[10:2]];
  assign rresp = 2'b00;
  assign do_b = aw_got && w_got && !bvalid;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0; waddr_word <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0; bvalid <= 0; bresp <= 0;
      s_awaddr <= 0; s_araddr <= 0; s_wdata <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      r_cnt <= ar_got ? r_cnt + 1 : 0;
      if (awvalid && awready) begin aw_got <= 1; s_awaddr <= awaddr; end
      if (wvalid && wready) begin w_got <= 1; s_wdata <= wdata; end
      if (bvalid && bready) begin bvalid <= 0; b_cnt <= b_cnt + 1; end
      else if (do_b) begin
        bvalid <= 1; bresp <= bresp_k; aw_got <= 0; w_got <= 0; waddr_word <= int'(s_awaddr[10:2]);
      end
      if (arvalid && arready) begin ar_got <= 1; s_araddr <= araddr; end
      if (rvalid && rready) ar_got <= 0;
    end

  always @(posedge clk)
    if (rst_n && do_b) mem[s_awaddr[10:2]] <= s_wdata;

  task automatic issue(input logic w, input logic [10:0] a, input logic [31:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, busy} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, timeout_err, busy});
    end
    n_cmp++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write, awprot, arprot} !== '0) begin
      n_fail++; $display("FAIL reset_data: awaddr %h araddr %h wdata %h rdata %h want 0", awaddr, araddr, wdata, rsp_rdata);
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    int n;
    issue(1, 11'h010, 32'hDEADBEEF);
    n_cmp++;
    if ({awvalid, wvalid, bready, cmd_ready, busy} !== 5'b11101 || awaddr !== 11'h010 || wstrb !== 4'hF) begin
      n_fail++; $display("FAIL write_issue: vwbcb %b awaddr %h strb %h want 11101 010 f", {awvalid, wvalid, bready, cmd_ready, busy}, awaddr, wstrb);
    end
    wait_rsp(n);
    n_cmp++;
    if (!rsp_valid || n != 3) begin n_fail++; $display("FAIL write_latency: valid %b cycles %0d want 1 3", rsp_valid, n); end
    n_cmp++;
    if (rsp_write !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL write_rsp: write %b resp %b rdata %h want 1 00 0", rsp_write, rsp_resp, rsp_rdata);
    end
    n_cmp++;
    if (waddr_word != 4) begin n_fail++; $display("FAIL write_slave_addr: got %0d want 4", waddr_word); end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_rsp_pulse: rsp_valid %b cmd_ready %b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read;
    int n;
    issue(0, 11'h013, 32'h0);
    n_cmp++;
    if (arvalid !== 1'b1 || araddr !== 11'h010 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_issue: arvalid %b araddr %h awvalid %b want 1 010 0", arvalid, araddr, awvalid);
    end
    wait_rsp(n);
    n_cmp++;
    if (!rsp_valid || n != 2) begin n_fail++; $display("FAIL read_latency: valid %b cycles %0d want 1 2", rsp_valid, n); end
    n_cmp++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp: rdata %h resp %b write %b want deadbeef 00 0", rsp_rdata, rsp_resp, rsp_write);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_independent_aw_w;
    int n, b0;
    aw_dly = 3; w_dly = 0; bresp_k = 2'b10;
    b0 = b_cnt;
    issue(1, 11'h020, 32'h000000AA);
    @(posedge clk); #1;
    n_cmp++;
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
      n_fail++; $display("FAIL indep_w_drop: wvalid %b awvalid %b want 0 1", wvalid, awvalid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (awvalid !== 1'b1 || bready !== 1'b1) begin
      n_fail++; $display("FAIL indep_aw_hold: awvalid %b bready %b want 1 1", awvalid, bready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (awvalid !== 1'b0) begin n_fail++; $display("FAIL indep_aw_drop: awvalid %b want 0", awvalid); end
    wait_rsp(n);
    n_cmp++;
    if (!rsp_valid || rsp_resp !== 2'b10 || rsp_write !== 1'b1) begin
      n_fail++; $display("FAIL indep_rsp: valid %b resp %b write %b want 1 10 1", rsp_valid, rsp_resp, rsp_write);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (b_cnt != b0 + 1) begin n_fail++; $display("FAIL indep_b_count: got %0d want %0d", b_cnt - b0, 1); end
    aw_dly = 0; bresp_k = 2'b00;
  endtask

  task automatic test_backpressure;
    int i;
    logic bad;
    r_dly = 5; rsp_ready = 0; bad = 0; i = 1;
    issue(0, 11'h010, 32'h0);
    while (!rsp_valid && i < 20) begin
      if ((i >= 2 && rready !== 1'b1) || cmd_ready !== 1'b0) bad = 1;
      @(posedge clk); #1;
      i++;
    end
    n_cmp++;
    if (bad || i != 8 || !rsp_valid) begin
      n_fail++; $display("FAIL bp_wait: rready_bad %b rsp_cycle %0d want 0 8", bad, i);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_write !== 1'b0 || cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid %b rdata %h write %b cmd_ready %b want 1 deadbeef 0 0", k, rsp_valid, rsp_rdata, rsp_write, cmd_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: rsp_valid %b cmd_ready %b want 0 1", rsp_valid, cmd_ready);
    end
    r_dly = 0;
  endtask

  task automatic test_watchdog;
    int n;
    ar_dly = 1000;
    issue(0, 11'h010, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wd_early: timeout_err %b want 0", timeout_err); end
    @(posedge clk); #1;
    n_cmp++;
    if (timeout_err !== 1'b1 || arvalid !== 1'b1) begin
      n_fail++; $display("FAIL wd_set: timeout_err %b arvalid %b want 1 1", timeout_err, arvalid);
    end
    timeout_clr = 1;
    @(posedge clk); #1;
    timeout_clr = 0;
    n_cmp++;
    if (timeout_err !== 1'b0 || arvalid !== 1'b1) begin
      n_fail++; $display("FAIL wd_clear: timeout_err %b arvalid %b want 0 1", timeout_err, arvalid);
    end
    ar_dly = 0;
    wait_rsp(n);
    n_cmp++;
    if (!rsp_valid || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
      n_fail++; $display("FAIL wd_late_read: valid %b rdata %h resp %b want 1 deadbeef 00", rsp_valid, rsp_rdata, rsp_resp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write;
    int n;
    aw_dly = 1000;
    issue(1, 11'h030, 32'h5A5A5A5A);
    n_cmp++;
    if (awvalid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: awvalid %b want 1", awvalid); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async: aw/w/b/busy %b want 0000", {awvalid, wvalid, bready, busy});
    end
    @(negedge clk);
    rst_n = 1; aw_dly = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: cmd_ready %b busy %b want 1 0", cmd_ready, busy);
    end
    issue(0, 11'h010, 32'h0);
    wait_rsp(n);
    n_cmp++;
    if (!rsp_valid || rsp_rdata !== 32'hDEADBEEF || rsp_write !== 1'b0) begin
      n_fail++; $display("FAIL rst_read: valid %b rdata %h write %b want 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_write);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_independent_aw_w;
    test_backpressure;
    test_watchdog;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
